// File: rtl/fp_rf_pkg.sv
// Shared constants and types for the FP register file write-port controller.
package fp_rf_pkg;

   localparam int NUM_FREGS = 32;
   localparam int FREG_AW   = 5;
   localparam int FLEN      = 64;

   typedef logic [FREG_AW-1:0] freg_addr_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      BREAK = 2'd2
   } wctrl_state_e;

endpackage

// File: rtl/fp_regfile_write_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int N  = 3,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   logic w_found;

   // Scan ptr+1, ptr+2, ... and grant the first active requester
   always_comb begin
      grant   = '0;
      w_found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         for (int j = 0; j < N; j++) begin
            if (!w_found && req[j] && (j == ((int'(ptr) + k) % N))) begin
               grant[j] = 1'b1;
               w_found  = 1'b1;
            end else begin
               w_found = w_found;
            end
         end
      end
   end

endmodule

// File: rtl/fp_regfile_write_ctrl.sv
// FP regfile write-port controller: round-robin write arbitration, read/write
// collision breaking and a per-register busy scoreboard for the issue stage.
module fp_regfile_write_ctrl
   import fp_rf_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int DW    = 64,
   parameter int AW    = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [N_REQ*AW-1:0]  req_addr,
   input  logic [N_REQ*DW-1:0]  req_data,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [AW-1:0]        rd_raddr1,
   input  logic [AW-1:0]        rd_raddr2,
   input  logic [AW-1:0]        rd_raddr3,
   output logic                 rd_stall,
   output logic [AW-1:0]        rf_raddr1,
   output logic [AW-1:0]        rf_raddr2,
   output logic [AW-1:0]        rf_raddr3,
   output logic [AW-1:0]        rf_waddr,
   output logic [DW-1:0]        rf_wdata,
   output logic                 rf_wen,
   input  logic                 sb_set_valid,
   input  logic [AW-1:0]        sb_set_addr,
   output logic [NUM_FREGS-1:0] sb_busy,
   output logic [2:0]           hazard
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   wctrl_state_e         r_state;
   logic [AW-1:0]        r_addr;
   logic [DW-1:0]        r_data;
   logic [PW-1:0]        r_ptr;
   logic [NUM_FREGS-1:0] r_busy;

   logic [N_REQ-1:0]     w_grant;
   logic [PW-1:0]        w_gidx;
   logic [AW-1:0]        w_sel_addr;
   logic [DW-1:0]        w_sel_data;
   logic                 w_coll;
   logic                 w_commit;
   logic                 w_can_accept;
   logic                 w_stall;
   logic                 w_accept;
   logic [NUM_FREGS-1:0] w_set_mask;
   logic [NUM_FREGS-1:0] w_clr_mask;

   rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
      .req   (req_valid),
      .ptr   (r_ptr),
      .grant (w_grant)
   );

   assign w_coll = (r_addr == rd_raddr1) || (r_addr == rd_raddr2) || (r_addr == rd_raddr3);

   // Per-state commit/accept/stall decode
   always_comb begin
      w_commit     = 1'b0;
      w_can_accept = 1'b0;
      w_stall      = 1'b0;
      case (r_state)
         IDLE: begin
            w_can_accept = 1'b1;
         end
         HOLD: begin
            if (!w_coll) begin
               w_commit     = 1'b1;
               w_can_accept = 1'b1;
            end else begin
               w_commit     = 1'b0;
               w_can_accept = 1'b0;
            end
         end
         BREAK: begin
            w_commit = 1'b1;
            w_stall  = 1'b1;
         end
         default: begin
            w_commit     = 1'b0;
            w_can_accept = 1'b0;
            w_stall      = 1'b0;
         end
      endcase
   end

   // Granted index and its address/data, selected from the packed buses
   always_comb begin
      w_gidx     = '0;
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_grant[i]) begin
            w_gidx     = PW'(i);
            w_sel_addr = req_addr[i*AW +: AW];
            w_sel_data = req_data[i*DW +: DW];
         end else begin
            w_gidx = w_gidx;
         end
      end
   end

   assign req_ready = w_grant & {N_REQ{w_can_accept & rst_n}};
   assign w_accept  = |req_ready;
   assign rf_wen    = w_commit & rst_n;
   assign rd_stall  = w_stall;
   assign rf_waddr  = r_addr;
   assign rf_wdata  = r_data;

   // During a break all read ports are steered off the write address
   assign rf_raddr1 = w_stall ? (r_addr ^ AW'(1)) : rd_raddr1;
   assign rf_raddr2 = w_stall ? (r_addr ^ AW'(1)) : rd_raddr2;
   assign rf_raddr3 = w_stall ? (r_addr ^ AW'(1)) : rd_raddr3;

   // Write-port FSM with holding register and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_data  <= '0;
         r_ptr   <= PW'(N_REQ - 1);
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state <= HOLD;
                  r_addr  <= w_sel_addr;
                  r_data  <= w_sel_data;
                  r_ptr   <= w_gidx;
               end else begin
                  r_state <= IDLE;
               end
            end
            HOLD: begin
               if (w_coll) begin
                  r_state <= BREAK;
               end else if (w_accept) begin
                  r_state <= HOLD;
                  r_addr  <= w_sel_addr;
                  r_data  <= w_sel_data;
                  r_ptr   <= w_gidx;
               end else begin
                  r_state <= IDLE;
               end
            end
            BREAK: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign w_set_mask = sb_set_valid ? (NUM_FREGS'(1) << sb_set_addr) : '0;
   assign w_clr_mask = rf_wen ? (NUM_FREGS'(1) << r_addr) : '0;

   // Busy scoreboard: a same-cycle set overrides the commit clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
      end
   end

   assign sb_busy   = r_busy;
   assign hazard[0] = r_busy[rd_raddr1];
   assign hazard[1] = r_busy[rd_raddr2];
   assign hazard[2] = r_busy[rd_raddr3];

endmodule

// File: doc/fp_regfile_write_ctrl.md
Name: fp_regfile_write_ctrl

Overview:
- Write-port controller and scoreboard for the 32 x 64-bit FP register file.
- Arbitrates N_REQ writers (FPU result, FP load, int-to-FP move) onto the single write port using round-robin.
- The regfile commits a write only when waddr differs from all three read addresses, so this block detects collisions and breaks them.
- Keeps a per-register busy scoreboard for the issue stage.

Parameters:
N_REQ, 3, number of write requesters
DW, 64, register data width
AW, 5, register address width (32 registers)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester write request
req_addr  in  N_REQ*AW  packed destination addresses, requester i at [i*AW +: AW]
req_data  in  N_REQ*DW  packed write data, requester i at [i*DW +: DW]
req_ready  out  N_REQ  per-requester accept, one-hot or zero
rd_raddr1  in  AW  read address 1 from the read stage
rd_raddr2  in  AW  read address 2 from the read stage
rd_raddr3  in  AW  read address 3 from the read stage
rd_stall  out  1  read stage must hold; its read data is invalid this cycle
rf_raddr1  out  AW  read address 1 driven to the regfile
rf_raddr2  out  AW  read address 2 driven to the regfile
rf_raddr3  out  AW  read address 3 driven to the regfile
rf_waddr  out  AW  write address driven to the regfile
rf_wdata  out  DW  write data driven to the regfile
rf_wen  out  1  write enable driven to the regfile
sb_set_valid  in  1  issue stage marks a destination register pending
sb_set_addr  in  AW  destination register to mark pending
sb_busy  out  32  scoreboard busy vector
hazard  out  3  hazard[k] = sb_busy[rd_raddr(k+1)]

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset state: state=IDLE, holding register cleared, sb_busy=0, RR pointer=N_REQ-1 (requester 0 wins first).
- Outputs during reset: req_ready=0, rf_wen=0, rd_stall=0, rf_raddrK=rd_raddrK.
- FSM states: IDLE (holding register empty), HOLD (one write pending), BREAK (collision break).
- Handshake: a transfer occurs when req_valid[i] && req_ready[i].
  - Only the granted requester sees ready.
  - Ready is high in IDLE, and in HOLD when the pending write commits that cycle.
  - Never high in BREAK.
- Accept: latch addr and data into the holding register and go to HOLD. The RR pointer moves to the granted index.
- Grant: the first valid requester at index pointer+1, +2, ... (mod N_REQ).
- HOLD, no collision (rf_waddr differs from all rd_raddrK):
  - rf_wen=1, the write commits at this edge.
  - Next state is HOLD if a new request is accepted in the same cycle, else IDLE.
  - Throughput is one write per cycle.
- HOLD, collision: rf_wen=0, no accept, next state BREAK.
- BREAK:
  - rd_stall=1.
  - All rf_raddrK = rf_waddr ^ 5'd1, guaranteed distinct from waddr.
  - rf_wen=1, commit, then go to IDLE.
- Outside BREAK: rf_raddrK = rd_raddrK and rd_stall=0.
- Latency: a request accepted in cycle t commits at the end of t+1. With a collision it commits at the end of t+2.
- Writes to x0 (f0) are legal. FP registers have no hardwired zero.
- Scoreboard:
  - sb_busy[sb_set_addr] is set when sb_set_valid.
  - sb_busy[rf_waddr] is cleared when rf_wen.
  - Set and clear to the same address in the same cycle: set wins.
  - Setting an already-busy bit leaves it at 1 (no counting).
- hazard is combinational from the current sb_busy. A same-cycle clear is not forwarded.
- Reset mid-operation: a pending write is discarded (not committed) and the scoreboard clears. Requesters must re-issue.
- Holding-register data and addr are don't-care in IDLE. rf_wen must never assert in IDLE.

Decomposition:
- Package fp_rf_pkg holds:
  - constants NUM_FREGS=32, FREG_AW=5, FLEN=64
  - typedef freg_addr_t
  - enum wctrl_state_e {IDLE, HOLD, BREAK}
- Sub-module rr_arbiter (parameter N; inputs req and ptr, output one-hot grant). It is natural and reusable.

Test Plan:
1. Reset, then requester 1 valid with addr=3, data=64'hDEAD_BEEF, rd_raddr=0/1/2 -> ready[1] in cycle 0; rf_wen=1 with waddr=3 in cycle 1; sb_busy[3] cleared.
2. All three requesters valid continuously with distinct addrs 4/5/6 -> grants 0,1,2,0...; one rf_wen per cycle; no starvation.
3. Pending write addr=7 while rd_raddr2=7 -> HOLD with rf_wen=0. Next cycle BREAK: rd_stall=1, rf_raddr1..3=6, rf_wen=1, waddr=7. Following cycle ready again.
4. sb_set_valid with addr=9 while a write to 9 commits in the same cycle -> sb_busy[9]=1 afterwards; hazard[0]=1 when rd_raddr1=9.
5. Assert rst_n low while in HOLD with addr=12 -> rf_wen stays 0; state IDLE; sb_busy=0; regfile f12 unchanged.
6. Write to addr=0 with data=64'h3FF0_0000_0000_0000 -> committed to f0, treated like any other register.
